// File: rtl/mv_line_ctrl_pkg.sv
// Shared widths, neighbour slot indices and FSM encoding for the MV line-buffer controller.
package mv_line_ctrl_pkg;

  localparam int MV_W      = 16;
  localparam int ADDRWIDTH = 9;
  localparam int MBX_W     = 7;

  // Neighbour slot order, also the read issue order and the packing order of nb_mv_o.
  localparam logic [2:0] NB_TL = 3'd0;
  localparam logic [2:0] NB_T0 = 3'd1;
  localparam logic [2:0] NB_T1 = 3'd2;
  localparam logic [2:0] NB_T2 = 3'd3;
  localparam logic [2:0] NB_T3 = 3'd4;
  localparam logic [2:0] NB_TR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD      = 2'd2,
    ST_RD_TAIL = 2'd3
  } state_t;

  // First word of an MB column in the line RAM (4 words per column).
  function automatic logic [ADDRWIDTH-1:0] mb_base(input logic [MBX_W-1:0] mb_x);
    return {mb_x, 2'b00};
  endfunction

endpackage

// File: rtl/mv_nb_avail.sv
// Availability and RAM address of one neighbour slot of the current MB.
module mv_nb_avail
  import mv_line_ctrl_pkg::*;
(
  input  logic [MBX_W-1:0]     mb_x,
  input  logic [MBX_W-1:0]     mb_y,
  input  logic [MBX_W-1:0]     mb_x_total,
  input  logic [2:0]           slot,
  output logic                 avail,
  output logic [ADDRWIDTH-1:0] addr
);

  // Slots sit at consecutive addresses starting one word left of the column:
  // TL = 4x-1, T0..T3 = 4x..4x+3, TR = 4x+4 = first word of column x+1.
  always_comb begin
    addr  = mb_base(mb_x) + ADDRWIDTH'(slot) - ADDRWIDTH'(1);
    avail = (mb_y != '0);
    if (slot == NB_TL) begin
      avail = avail && (mb_x != '0);
    end else if (slot == NB_TR) begin
      avail = avail && (mb_x != mb_x_total);
    end
  end

endmodule

// File: rtl/mv_line_ctrl.sv
// MV line-buffer controller: serialises bottom-row MV stores and neighbour
// fetches on the single-port line RAM.
//
//   state      | meaning
//   ST_IDLE    | no operation running; pending ops or fresh starts are accepted
//   ST_WR      | issuing the 4 bottom-row writes, one per cycle
//   ST_RD      | issuing the 6 neighbour slots TL,T0..T3,TR, capturing the previous slot
//   ST_RD_TAIL | capturing TR data, publishing nb outputs with rd_done_o
module mv_line_ctrl
  import mv_line_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MBX_W-1:0]     mb_x_i,
  input  logic [MBX_W-1:0]     mb_y_i,
  input  logic [MBX_W-1:0]     mb_x_total_i,
  input  logic                 rd_start_i,
  input  logic                 wr_start_i,
  input  logic [4*MV_W-1:0]    wr_mv_i,
  output logic                 busy_o,
  output logic                 rd_done_o,
  output logic                 wr_done_o,
  output logic [6*MV_W-1:0]    nb_mv_o,
  output logic [5:0]           nb_avail_o,
  output logic                 ram_ce_o,
  output logic                 ram_we_o,
  output logic [ADDRWIDTH-1:0] ram_addr_o,
  output logic [MV_W-1:0]      ram_data_o,
  input  logic [MV_W-1:0]      ram_data_i
);

  state_t                 state;
  logic [2:0]             cnt;
  logic [MBX_W-1:0]       cur_x, cur_y, cur_tot;
  logic [4*MV_W-1:0]      cur_mv;
  logic                   pend_wr, pend_rd;
  logic [MBX_W-1:0]       pwr_x;
  logic [4*MV_W-1:0]      pwr_mv;
  logic [MBX_W-1:0]       prd_x, prd_y, prd_tot;
  logic [5*MV_W-1:0]      shadow_mv;
  logic [4:0]             shadow_avail;
  logic                   slot_avail;
  logic [ADDRWIDTH-1:0]   slot_addr;
  logic                   cap_valid;
  logic [MV_W-1:0]        cap_word;
  logic                   op_end, can_start, go_wr, go_rd, latch_wr, latch_rd;

  mv_nb_avail u_nb_avail (
    .mb_x       (cur_x),
    .mb_y       (cur_y),
    .mb_x_total (cur_tot),
    .slot       (cnt),
    .avail      (slot_avail),
    .addr       (slot_addr)
  );

  assign busy_o = (state != ST_IDLE) || pend_wr || pend_rd;

  // Next-op arbitration (write always first, so a following read sees fresh TR data)
  // and the capture word for the read issued in the previous cycle.
  always_comb begin
    op_end    = ((state == ST_WR) && (cnt == 3'd3)) || (state == ST_RD_TAIL);
    can_start = (state == ST_IDLE) || op_end;
    go_wr     = can_start && (pend_wr || ((state == ST_IDLE) && wr_start_i));
    go_rd     = can_start && !go_wr && (pend_rd || ((state == ST_IDLE) && rd_start_i));
    latch_wr  = wr_start_i && !pend_wr && (state != ST_IDLE);
    latch_rd  = rd_start_i && !pend_rd && ((state != ST_IDLE) || go_wr);
    cap_valid = ram_ce_o && !ram_we_o;
    cap_word  = cap_valid ? ram_data_i : '0;
  end

  // Controller FSM with pending latches, operand capture and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      cur_tot      <= '0;
      cur_mv       <= '0;
      pend_wr      <= 1'b0;
      pend_rd      <= 1'b0;
      pwr_x        <= '0;
      pwr_mv       <= '0;
      prd_x        <= '0;
      prd_y        <= '0;
      prd_tot      <= '0;
      shadow_mv    <= '0;
      shadow_avail <= '0;
      rd_done_o    <= 1'b0;
      wr_done_o    <= 1'b0;
      nb_mv_o      <= '0;
      nb_avail_o   <= '0;
      ram_ce_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
    end else begin
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      rd_done_o  <= 1'b0;
      wr_done_o  <= 1'b0;

      if (latch_wr) begin
        pend_wr <= 1'b1;
        pwr_x   <= mb_x_i;
        pwr_mv  <= wr_mv_i;
      end
      if (latch_rd) begin
        pend_rd <= 1'b1;
        prd_x   <= mb_x_i;
        prd_y   <= mb_y_i;
        prd_tot <= mb_x_total_i;
      end

      case (state)
        ST_WR: begin
          ram_ce_o   <= 1'b1;
          ram_we_o   <= 1'b1;
          ram_addr_o <= mb_base(cur_x) + ADDRWIDTH'(cnt);
          ram_data_o <= cur_mv[MV_W-1:0];
          cur_mv     <= cur_mv >> MV_W;
          cnt        <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            wr_done_o <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_RD: begin
          // Five shifts (slots TL..T3) leave TL in the lowest word.
          if (cnt != 3'd0) begin
            shadow_mv    <= {cap_word, shadow_mv[5*MV_W-1:MV_W]};
            shadow_avail <= {cap_valid, shadow_avail[4:1]};
          end
          if (slot_avail) begin
            ram_ce_o   <= 1'b1;
            ram_addr_o <= slot_addr;
          end
          cnt <= cnt + 3'd1;
          if (cnt == NB_TR) state <= ST_RD_TAIL;
        end
        ST_RD_TAIL: begin
          nb_mv_o    <= {cap_word, shadow_mv};
          nb_avail_o <= {cap_valid, shadow_avail};
          rd_done_o  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: ;
      endcase

      if (go_wr) begin
        state <= ST_WR;
        cnt   <= '0;
        if (pend_wr) begin
          pend_wr <= 1'b0;
          cur_x   <= pwr_x;
          cur_mv  <= pwr_mv;
        end else begin
          cur_x   <= mb_x_i;
          cur_mv  <= wr_mv_i;
        end
      end else if (go_rd) begin
        state <= ST_RD;
        cnt   <= '0;
        if (pend_rd) begin
          pend_rd <= 1'b0;
          cur_x   <= prd_x;
          cur_y   <= prd_y;
          cur_tot <= prd_tot;
        end else begin
          cur_x   <= mb_x_i;
          cur_y   <= mb_y_i;
          cur_tot <= mb_x_total_i;
        end
      end
    end
  end

endmodule
